// File: rtl/des_result_serializer.sv
// -----------------------------------------------------------------------------
// des_result_serializer
//
// Byte-wide transmit stage for the DES datapath. Each 64-bit block presented
// by the DES core with a one-cycle result_valid strobe is captured and sent
// as eight bytes over a valid/ready byte interface. A single pending-block
// buffer absorbs a second block while the sink stalls; a third block that
// arrives before the active block finishes is dropped and flagged.
//
// Parameters
//   MSB_FIRST     1: send result[63:56] first and [7:0] last; 0: reverse order
//
// Ports
//   clk           in   system clock (same clock as the DES core)
//   rst_n         in   asynchronous active-low reset
//   result        in   64-bit DES output block, sampled when result_valid=1
//   result_valid  in   one-cycle strobe from the DES core, no backpressure
//   byte_out      out  current output byte
//   byte_valid    out  byte_out holds a valid byte
//   byte_ready    in   sink accepts the byte (transfer = byte_valid & byte_ready)
//   byte_last     out  current byte is the 8th byte of its block
//   busy          out  active or pending block occupied
//   overflow      out  sticky; set when an incoming block is dropped
//   overflow_clr  in   synchronous clear of overflow (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module des_result_serializer #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] result,
    input  logic        result_valid,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        byte_last,
    output logic        busy,
    output logic        overflow,
    input  logic        overflow_clr
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      state;
    logic [63:0] act;
    logic [63:0] pend;
    logic [2:0]  idx;
    logic        pend_v;
    logic        ovf_q;

    logic        xfer;
    logic        end_of_block;
    logic        drop;
    logic [63:0] act_shifted;

    assign xfer         = (state == SEND) && byte_ready;
    assign end_of_block = xfer && (idx == 3'd7);

    // A block arriving while SEND is not finishing, with the buffer already
    // full, has nowhere to go.
    assign drop = (state == SEND) && !end_of_block && result_valid && pend_v;

    // Move the next byte into the output end of the active register.
    assign act_shifted = MSB_FIRST ? {act[55:0], 8'h00} : {8'h00, act[63:8]};

    // Outputs decode only registered state, so byte_ready/result_valid never
    // reach an output combinationally and a stalled byte stays put.
    assign byte_out   = MSB_FIRST ? act[63:56] : act[7:0];
    assign byte_valid = (state == SEND);
    assign byte_last  = (state == SEND) && (idx == 3'd7);
    assign busy       = (state == SEND) || pend_v;
    assign overflow   = ovf_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data registers are reset too (not just the flags), so
            // byte_out reads 0 in reset and no stale block can leak out later.
            state  <= IDLE;
            act    <= 64'h0;
            pend   <= 64'h0;
            idx    <= 3'd0;
            pend_v <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (result_valid) begin
                        act   <= result;
                        idx   <= 3'd0;
                        state <= SEND;
                    end
                end

                SEND: begin
                    if (end_of_block) begin
                        if (pend_v) begin
                            // Buffered block goes next; a coincident new block
                            // refills the buffer so nothing is lost.
                            act <= pend;
                            idx <= 3'd0;
                            if (result_valid) begin
                                pend <= result;
                            end else begin
                                pend_v <= 1'b0;
                            end
                        end else if (result_valid) begin
                            // Zero-bubble handoff straight into the active slot.
                            act <= result;
                            idx <= 3'd0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        if (xfer) begin
                            act <= act_shifted;
                            idx <= idx + 3'd1;
                        end
                        if (result_valid && !pend_v) begin
                            pend   <= result;
                            pend_v <= 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase

            // Set has priority over clear so a drop is never hidden.
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (overflow_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_des_result_serializer.sv
// -----------------------------------------------------------------------------
// tb_des_result_serializer
//
// Self-checking bench for des_result_serializer. Two instances share the
// clock: one MSB-first (main traffic, scoreboarded) and one LSB-first
// (byte order and reset-mid-block sequence).
// -----------------------------------------------------------------------------
module tb_des_result_serializer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // MSB-first instance
    logic        rst_n;
    logic [63:0] result;
    logic        result_valid;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        byte_last;
    logic        busy;
    logic        overflow;
    logic        overflow_clr;

    // LSB-first instance
    logic        l_rst_n;
    logic [63:0] l_result;
    logic        l_result_valid;
    logic [7:0]  l_byte_out;
    logic        l_byte_valid;
    logic        l_byte_ready;
    logic        l_byte_last;
    logic        l_busy;
    logic        l_overflow;
    logic        l_overflow_clr;

    des_result_serializer #(.MSB_FIRST(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .result       (result),
        .result_valid (result_valid),
        .byte_out     (byte_out),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .byte_last    (byte_last),
        .busy         (busy),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    des_result_serializer #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk          (clk),
        .rst_n        (l_rst_n),
        .result       (l_result),
        .result_valid (l_result_valid),
        .byte_out     (l_byte_out),
        .byte_valid   (l_byte_valid),
        .byte_ready   (l_byte_ready),
        .byte_last    (l_byte_last),
        .busy         (l_busy),
        .overflow     (l_overflow),
        .overflow_clr (l_overflow_clr)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard of expected bytes for the MSB-first instance: {last, byte}.
    logic [8:0] sb[$];
    int         xfer_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte;
    logic       prev_last;

    task automatic push_block(input logic [63:0] d);
        for (int i = 0; i < 8; i++) begin
            sb.push_back({(i == 7), d[63 - 8*i -: 8]});
        end
    endtask

    // Monitor: sampled on the falling edge, half a cycle from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall && byte_valid) begin
                check("stall_hold_byte", byte_out, prev_byte);
                check("stall_hold_last", byte_last, prev_last);
            end
            if (byte_valid && byte_ready) begin
                xfer_cnt++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got byte %0h, expected no transfer", byte_out);
                end else begin
                    logic [8:0] e;
                    e = sb.pop_front();
                    check("sb_byte", byte_out, e[7:0]);
                    check("sb_last", byte_last, e[8]);
                end
            end
            prev_stall = byte_valid && !byte_ready;
            prev_byte  = byte_out;
            prev_last  = byte_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [63:0] d);
        result       = d;
        result_valid = 1'b1;
        step();
        result_valid = 1'b0;
    endtask

    typedef struct {
        logic [63:0] data;
        logic [7:0]  first_b;
        logic [7:0]  last_b;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] exp1[8];
    logic [7:0] exp_lsb[8];
    logic [2:0] pat[3];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{64'hFFFFFFFFFFFFFFFF, 8'hFF, 8'hFF};
        vecs[1] = '{64'h0000000000000000, 8'h00, 8'h00};
        vecs[2] = '{64'h8000000000000001, 8'h80, 8'h01};
        vecs[3] = '{64'hA5A55A5AC3C33C3C, 8'hA5, 8'h3C};
        vecs[4] = '{64'hDEADBEEFCAFEF00D, 8'hDE, 8'h0D};
        exp1    = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        exp_lsb = '{8'h87, 8'h96, 8'hA5, 8'hB4, 8'hC3, 8'hD2, 8'hE1, 8'hF0};
        pat     = '{3'd1, 3'd0, 3'd0};

        rst_n = 1'b0; result = '0; result_valid = 1'b0; byte_ready = 1'b0; overflow_clr = 1'b0;
        l_rst_n = 1'b0; l_result = '0; l_result_valid = 1'b0; l_byte_ready = 1'b0; l_overflow_clr = 1'b0;

        // ---------------- reset state ----------------
        #12;
        check("rst_byte_out",   byte_out,   8'h00);
        check("rst_byte_valid", byte_valid, 1'b0);
        check("rst_byte_last",  byte_last,  1'b0);
        check("rst_busy",       busy,       1'b0);
        check("rst_overflow",   overflow,   1'b0);
        check("rst_lsb_busy",   l_busy,     1'b0);
        step();
        rst_n = 1'b1; l_rst_n = 1'b1;
        step();

        // ---------------- single block, cycle-exact ----------------
        byte_ready = 1'b1;
        push_block(64'h0123456789ABCDEF);
        strobe(64'h0123456789ABCDEF);
        for (int i = 0; i < 8; i++) begin
            check("single_valid", byte_valid, 1'b1);
            check("single_byte",  byte_out,   exp1[i]);
            check("single_last",  byte_last,  (i == 7));
            step();
        end
        check("single_busy_end",  busy,       1'b0);
        check("single_valid_end", byte_valid, 1'b0);

        // ---------------- table-driven blocks ----------------
        for (int v = 0; v < 5; v++) begin
            push_block(vecs[v].data);
            strobe(vecs[v].data);
            check("vec_first", byte_out, vecs[v].first_b);
            repeat (7) step();
            check("vec_last_byte", byte_out,  vecs[v].last_b);
            check("vec_last_flag", byte_last, 1'b1);
            step();
            check("vec_busy_end", busy, 1'b0);
        end
        check("vec_sb_empty", sb.size(), 0);

        // ---------------- stall pattern 1,0,0,... ----------------
        byte_ready = 1'b0;
        push_block(64'h0123456789ABCDEF);
        strobe(64'h0123456789ABCDEF);
        xfer_cnt = 0;
        for (int c = 0; c < 100 && xfer_cnt < 8; c++) begin
            byte_ready = pat[c % 3][0];
            step();
        end
        byte_ready = 1'b0;
        check("stall_xfers",    xfer_cnt,  8);
        check("stall_sb_empty", sb.size(), 0);
        check("stall_busy_end", busy,      1'b0);
        step();
        check("stall_no_extra", xfer_cnt,  8);

        // ---------------- back-to-back on byte_last transfer ----------------
        byte_ready = 1'b1;
        push_block(64'h0011223344556677);
        strobe(64'h0011223344556677);
        for (int i = 0; i < 20 && !byte_last; i++) step();
        check("b2b_saw_last", byte_last, 1'b1);
        push_block(64'h8899AABBCCDDEEFF);
        strobe(64'h8899AABBCCDDEEFF);
        check("b2b_no_bubble", byte_valid, 1'b1);
        check("b2b_b_byte0",   byte_out,   8'h88);
        check("b2b_b_notlast", byte_last,  1'b0);
        check("b2b_overflow",  overflow,   1'b0);
        repeat (8) step();
        check("b2b_busy_end", busy,      1'b0);
        check("b2b_sb_empty", sb.size(), 0);

        // ---------------- overflow: A,B,C on successive cycles ----------------
        byte_ready = 1'b0;
        push_block(64'hA0A1A2A3A4A5A6A7);
        push_block(64'hB0B1B2B3B4B5B6B7);
        result_valid = 1'b1;
        result = 64'hA0A1A2A3A4A5A6A7; step();
        result = 64'hB0B1B2B3B4B5B6B7; step();
        check("ovf_before_c", overflow, 1'b0);
        result = 64'hC0C1C2C3C4C5C6C7; step();
        result_valid = 1'b0;
        check("ovf_set",     overflow, 1'b1);
        check("ovf_busy",    busy,     1'b1);
        check("ovf_a_first", byte_out, 8'hA0);
        repeat (3) step();
        check("ovf_held", overflow, 1'b1);
        byte_ready = 1'b1;
        repeat (16) step();
        check("ovf_drain_sb",    sb.size(), 0);
        check("ovf_drain_busy",  busy,      1'b0);
        check("ovf_still_set",   overflow,  1'b1);
        overflow_clr = 1'b1; step(); overflow_clr = 1'b0;
        check("ovf_cleared", overflow, 1'b0);

        // Drop coinciding with overflow_clr: set wins.
        byte_ready = 1'b0;
        push_block(64'hD0D1D2D3D4D5D6D7);
        push_block(64'hE0E1E2E3E4E5E6E7);
        result_valid = 1'b1;
        result = 64'hD0D1D2D3D4D5D6D7; step();
        result = 64'hE0E1E2E3E4E5E6E7; step();
        result = 64'hF0F1F2F3F4F5F6F7; overflow_clr = 1'b1; step();
        result_valid = 1'b0; overflow_clr = 1'b0;
        check("ovf_set_wins", overflow, 1'b1);
        overflow_clr = 1'b1; step(); overflow_clr = 1'b0;
        check("ovf_clr_again", overflow, 1'b0);
        byte_ready = 1'b1;
        repeat (16) step();
        check("ovf2_drain_sb",   sb.size(), 0);
        check("ovf2_drain_busy", busy,      1'b0);
        byte_ready = 1'b0;

        // ---------------- reset mid-block, LSB-first instance ----------------
        l_byte_ready   = 1'b1;
        l_result       = 64'h1122334455667788;
        l_result_valid = 1'b1;
        step();
        check("lsb_b0", l_byte_out, 8'h88);
        l_result = 64'hDEADBEEF00C0FFEE;   // lands in the pending buffer
        step();
        l_result_valid = 1'b0;
        check("lsb_b1",   l_byte_out, 8'h77);
        check("lsb_busy", l_busy,     1'b1);
        step();
        check("lsb_b2", l_byte_out, 8'h66);
        step();
        l_rst_n = 1'b0;
        #1;
        check("lsb_rst_byte",  l_byte_out,   8'h00);
        check("lsb_rst_valid", l_byte_valid, 1'b0);
        check("lsb_rst_last",  l_byte_last,  1'b0);
        check("lsb_rst_busy",  l_busy,       1'b0);
        check("lsb_rst_ovf",   l_overflow,   1'b0);
        step(); step();
        l_rst_n = 1'b1;
        step();
        check("lsb_post_idle", l_byte_valid, 1'b0);
        l_result       = 64'hF0E1D2C3B4A59687;
        l_result_valid = 1'b1;
        step();
        l_result_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("lsb_new_valid", l_byte_valid, 1'b1);
            check("lsb_new_byte",  l_byte_out,   exp_lsb[i]);
            check("lsb_new_last",  l_byte_last,  (i == 7));
            step();
        end
        check("lsb_new_busy_end", l_busy, 1'b0);

        check("final_sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
